// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state encoding and register-file constants for the hazard controller
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {RUN, MEMWAIT, ERROR} state_t;
  localparam int ZERO_REG_IDX = 31;
endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// load_use_detect: flags an ID source matching the destination of a load in EX
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [31:0] i_asel_id,
  input  logic [31:0] i_bsel_id,
  input  logic        i_buse_id,
  input  logic [31:0] i_dsel_ex,
  input  logic        i_lw_ex,
  output logic        o_load_use
);
  logic [31:0] w_mask;
  logic [31:0] w_src;
  // the zero register never carries a real dependency
  assign w_mask = ~(32'd1 << ZERO_REG_IDX);
  assign w_src = i_asel_id | (i_bsel_id & {32{i_buse_id}});
  assign o_load_use = i_lw_ex & |(i_dsel_ex & w_mask & w_src);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer with load-use detection, branch squash and dmem handshake
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      Asel_ID,
  input  logic [31:0]      Bsel_ID,
  input  logic             Buse_ID,
  input  logic [31:0]      Dsel_EX,
  input  logic             LW_EX,
  input  logic             LW_MEM,
  input  logic             SW_MEM,
  input  logic             BEQ_MEM,
  input  logic             BNE_MEM,
  input  logic             BLT_MEM,
  input  logic             BGE_MEM,
  input  logic             zcomp_MEM,
  input  logic             nzcomp_MEM,
  input  logic             neg_MEM,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             pc_sel,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  state_t            r_state, w_state_nxt;
  logic [WAIT_W-1:0] r_wait, w_wait_nxt, w_wait_inc;
  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;
  logic              w_mem_access, w_taken, w_load_use, w_freeze, w_err;
  logic              w_stall_inc, w_flush_inc, w_pc_sel, w_req;
  logic [4:0]        w_en;
  logic [2:0]        w_flush;

  load_use_detect u_lud (
    .i_asel_id (Asel_ID),
    .i_bsel_id (Bsel_ID),
    .i_buse_id (Buse_ID),
    .i_dsel_ex (Dsel_EX),
    .i_lw_ex   (LW_EX),
    .o_load_use(w_load_use)
  );

  always_comb begin
    w_err = r_state == ERROR;
    w_mem_access = LW_MEM | SW_MEM;
    w_taken = (BEQ_MEM & zcomp_MEM) | (BNE_MEM & nzcomp_MEM) | (BLT_MEM & neg_MEM) | (BGE_MEM & ~neg_MEM);
    w_freeze = w_err || (w_mem_access && !dmem_ack);
    w_wait_inc = r_wait + WAIT_W'(1);
    w_req = !w_err && w_mem_access;
    w_stall_inc = w_freeze ? !w_err : (!w_taken && w_load_use);
    w_flush_inc = !w_freeze && w_taken;
    w_pc_sel = !w_freeze && w_taken;
    w_en = w_freeze ? 5'b00000 : (!w_taken && w_load_use) ? 5'b00111 : 5'b11111;
    w_flush = w_freeze ? 3'b000 : w_taken ? 3'b111 : w_load_use ? 3'b010 : 3'b000;
    w_state_nxt = w_err ? ERROR : !w_freeze ? RUN :
                  (r_state == MEMWAIT && w_wait_inc == WAIT_W'(MEM_TIMEOUT)) ? ERROR : MEMWAIT;
    w_wait_nxt = (r_state == MEMWAIT && w_freeze) ? w_wait_inc : '0;
  end

  // reset forces a safe bubble-everything pattern without waiting for a clock
  assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = rst_n ? w_en : 5'b00000;
  assign {if_id_flush, id_ex_flush, ex_mem_flush} = rst_n ? w_flush : 3'b111;
  assign pc_sel = rst_n & w_pc_sel;
  assign dmem_req = rst_n & w_req;
  assign mem_err = w_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_wait <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait <= w_wait_nxt;
      if (w_stall_inc && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random stimulus checked against a rule-level reference model
module tb_pipeline_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 5;
  localparam int CMAX = 31;
  localparam logic [10:0] RSTV = 11'b00000_111_0_0_0;

  logic clk = 1'b0, rst_n = 1'b1;
  logic [31:0] Asel_ID, Bsel_ID, Dsel_EX;
  logic Buse_ID, LW_EX, LW_MEM, SW_MEM, BEQ_MEM, BNE_MEM, BLT_MEM, BGE_MEM;
  logic zcomp_MEM, nzcomp_MEM, neg_MEM, dmem_ack;
  logic dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, pc_sel, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [10:0] obs;

  int checks = 0, errors = 0;
  int m_err, m_wait, m_waited, m_stall, m_flush;
  int n_err, n_wait, n_waited, n_stall, n_flush;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .Asel_ID(Asel_ID), .Bsel_ID(Bsel_ID), .Buse_ID(Buse_ID),
    .Dsel_EX(Dsel_EX), .LW_EX(LW_EX), .LW_MEM(LW_MEM), .SW_MEM(SW_MEM),
    .BEQ_MEM(BEQ_MEM), .BNE_MEM(BNE_MEM), .BLT_MEM(BLT_MEM), .BGE_MEM(BGE_MEM),
    .zcomp_MEM(zcomp_MEM), .nzcomp_MEM(nzcomp_MEM), .neg_MEM(neg_MEM), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .pc_sel(pc_sel),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;
  assign obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
                ex_mem_flush, pc_sel, dmem_req, mem_err};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic clear();
    Asel_ID = 0; Bsel_ID = 0; Dsel_EX = 0; Buse_ID = 0; LW_EX = 0; LW_MEM = 0; SW_MEM = 0;
    BEQ_MEM = 0; BNE_MEM = 0; BLT_MEM = 0; BGE_MEM = 0;
    zcomp_MEM = 0; nzcomp_MEM = 0; neg_MEM = 0; dmem_ack = 0;
  endtask

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic model_eval(output logic [10:0] e);
    logic ma, tk, lu;
    ma = LW_MEM | SW_MEM;
    tk = (BEQ_MEM && zcomp_MEM) || (BNE_MEM && nzcomp_MEM) || (BLT_MEM && neg_MEM) || (BGE_MEM && !neg_MEM);
    lu = 1'b0;
    for (int i = 0; i < 31; i++)
      if (LW_EX && Dsel_EX[i] && (Asel_ID[i] || (Buse_ID && Bsel_ID[i]))) lu = 1'b1;
    n_err = m_err; n_wait = m_wait; n_waited = m_waited; n_stall = m_stall; n_flush = m_flush;
    if (m_err != 0) e = 11'b00000_000_0_0_1;
    else if (ma && !dmem_ack) begin
      e = 11'b00000_000_0_1_0;
      n_stall = sat(m_stall);
      if (m_wait != 0) begin
        n_waited = m_waited + 1;
        if (n_waited == TO) n_err = 1;
      end
      n_wait = 1;
    end else begin
      n_wait = 0; n_waited = 0;
      if (tk) begin
        e = {5'b11111, 3'b111, 1'b1, ma, 1'b0};
        n_flush = sat(m_flush);
      end else if (lu) begin
        e = {5'b00111, 3'b010, 1'b0, ma, 1'b0};
        n_stall = sat(m_stall);
      end else e = {5'b11111, 3'b000, 1'b0, ma, 1'b0};
    end
  endtask

  task automatic cyc(input string tag);
    logic [10:0] e;
    @(negedge clk);
    model_eval(e);
    chk({tag, "_ctl"}, 32'(obs), 32'(e));
    chk({tag, "_stall"}, 32'(stall_cnt), m_stall);
    chk({tag, "_flush"}, 32'(flush_cnt), m_flush);
    @(posedge clk);
    m_err = n_err; m_wait = n_wait; m_waited = n_waited; m_stall = n_stall; m_flush = n_flush;
    #1;
  endtask

  task automatic areset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_ctl"}, 32'(obs), 32'(RSTV));
    chk({tag, "_stall"}, 32'(stall_cnt), 0);
    chk({tag, "_flush"}, 32'(flush_cnt), 0);
    chk({tag, "_err"}, 32'(mem_err), 0);
    m_err = 0; m_wait = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [31:0] pick();
    return 32'd1 << (($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 3));
  endfunction

  task automatic rand_inputs();
    int r, b;
    Asel_ID = pick(); Bsel_ID = pick(); Dsel_EX = pick();
    Buse_ID = 1'($urandom_range(0, 1)); LW_EX = 1'($urandom_range(0, 1));
    r = $urandom_range(0, 9); LW_MEM = r == 0; SW_MEM = r == 1;
    b = $urandom_range(0, 7);
    BEQ_MEM = b == 0; BNE_MEM = b == 1; BLT_MEM = b == 2; BGE_MEM = b == 3;
    zcomp_MEM = 1'($urandom_range(0, 1)); nzcomp_MEM = 1'($urandom_range(0, 1));
    neg_MEM = 1'($urandom_range(0, 1)); dmem_ack = $urandom_range(0, 9) < 6;
  endtask

  initial begin
    clear();
    #1 areset("reset");
    cyc("normal");
    LW_EX = 1; Dsel_EX = 32'd1 << 5; Asel_ID = 32'd1 << 5;
    cyc("lu");
    chk("lu_cnt", 32'(stall_cnt), 1);
    clear();
    cyc("lu_after");
    LW_EX = 1; Dsel_EX = 32'd1 << 31; Asel_ID = 32'd1 << 31; Bsel_ID = 32'd1 << 31; Buse_ID = 1;
    cyc("zero_reg");
    LW_EX = 1; Dsel_EX = 32'd1 << 7; Bsel_ID = 32'd1 << 7; Asel_ID = 32'd1 << 2;
    cyc("lu_b");
    Buse_ID = 0;
    cyc("lu_b_unused");
    clear();
    BNE_MEM = 1; nzcomp_MEM = 1; LW_EX = 1; Dsel_EX = 32'd1 << 3; Asel_ID = 32'd1 << 3;
    cyc("taken_lu");
    chk("taken_flush_cnt", 32'(flush_cnt), 1);
    chk("taken_stall_cnt", 32'(stall_cnt), 2);
    clear(); BGE_MEM = 1; neg_MEM = 1;
    cyc("bge_not_taken");
    clear();
    areset("pre_wait");
    LW_MEM = 1;
    repeat (3) cyc("wait");
    dmem_ack = 1;
    cyc("wait_ack");
    chk("wait_stall_cnt", 32'(stall_cnt), 3);
    clear();
    cyc("after_wait");
    SW_MEM = 1;
    repeat (TO + 1) cyc("timeout");
    chk("timeout_err", 32'(mem_err), 1);
    dmem_ack = 1; LW_EX = 1; Dsel_EX = 32'd1; Asel_ID = 32'd1;
    repeat (2) cyc("error_hold");
    areset("err_reset");
    clear(); LW_MEM = 1;
    repeat (2) cyc("wait2");
    areset("mid_wait_reset");
    clear();
    LW_EX = 1; Dsel_EX = 32'd1 << 1; Asel_ID = 32'd1 << 1;
    repeat (CMAX + 4) cyc("sat");
    chk("sat_cnt", 32'(stall_cnt), CMAX);
    clear();
    for (int k = 0; k < 400; k++) begin
      if (k % 50 == 0) areset("rnd_rst");
      rand_inputs();
      cyc("rnd");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
